// File: rtl/approx_mult_seq.sv
// approx_mult_seq: sequential leading-one-truncation unsigned multiplier.
//
// Each operand is normalised by shifting left until its MSB is set. The
// number of shifts is accumulated in a shared counter. The top K bits of
// each normalised operand are multiplied and the product is placed at the
// top of a 2W-bit shift register. That register is then shifted right
// once per counted shift to denormalise it. A zero operand skips all of
// this and completes immediately with result 0 and zero_out set.
//
// Handshake: start is sampled only while idle (busy=0). a_in/b_in are
// captured on the same edge that accepts start. The block then raises busy.
// On completion, done pulses for one cycle and result/zero_out update in
// that cycle. result/zero_out hold until the next completion. A start that
// arrives while busy is dropped; it is not queued.
//
// Ports:
//   clk       clock, rising-edge
//   rst       synchronous active-low reset
//   start     operation request (sampled in IDLE only)
//   a_in      operand A, W bits
//   b_in      operand B, W bits
//   busy      high in every state except IDLE
//   done      one-cycle completion pulse
//   result    approximate product, 2W bits, held
//   zero_out  last operation took the zero early-out, held with result
//   dbg_state one-hot FSM state, for observation only
module approx_mult_seq #(
  parameter int W  = 16,
  parameter int K  = 8,
  parameter int CW = $clog2(2*W)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a_in,
  input  logic [W-1:0]   b_in,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic           zero_out,
  output logic [5:0]     dbg_state
);

  typedef enum logic [5:0] {
    S_IDLE   = 6'b000001,
    S_NORM_A = 6'b000010,
    S_NORM_B = 6'b000100,
    S_MUL    = 6'b001000,
    S_DENORM = 6'b010000,
    S_DONE   = 6'b100000
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] sh_q, sh_d;
  logic [2*W-1:0] result_q, result_d;
  logic           zero_q, zero_d;

  // The kept operand bits are zero-extended to 2K bits so that the
  // multiply produces its full-width result.
  logic [2*K-1:0] a_top, b_top, prod;

  always_comb begin
    a_top = {{K{1'b0}}, a_q[W-1 -: K]};
    b_top = {{K{1'b0}}, b_q[W-1 -: K]};
    prod  = a_top * b_top;
  end

  // State and datapath register. Reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      sh_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    result_d = result_q;
    zero_d   = zero_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d   = a_in;
          b_d   = b_in;
          cnt_d = '0;
          // A zero operand would never reach a set MSB, so finish now.
          if (a_in == '0 || b_in == '0) begin
            result_d = '0;
            zero_d   = 1'b1;
            state_d  = S_DONE;
          end else begin
            state_d = S_NORM_A;
          end
        end
      end
      S_NORM_A: begin
        if (a_q[W-1]) begin
          state_d = S_NORM_B;
        end else begin
          a_d   = a_q << 1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_NORM_B: begin
        if (b_q[W-1]) begin
          state_d = S_MUL;
        end else begin
          b_d   = b_q << 1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_MUL: begin
        // The product of the two kept fields sits at the top of the
        // 2W-bit register, which is the scale of the normalised operands.
        sh_d              = '0;
        sh_d[2*W-1 -: 2*K] = prod;
        state_d           = S_DENORM;
      end
      S_DENORM: begin
        if (cnt_q == '0) begin
          result_d = sh_q;
          zero_d   = 1'b0;
          state_d  = S_DONE;
        end else begin
          sh_d  = sh_q >> 1;
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    result    = result_q;
    zero_out  = zero_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_approx_mult_seq.sv
// Testbench for approx_mult_seq. It drives three instances: the default
// W=16,K=8 instance, a W=8,K=8 instance (exact) and a W=32,K=4 instance.
// Each operation is compared against a reference model built from the
// normalise/truncate/multiply/shift rule. The model checks the result,
// zero flag, latency, busy length, the single done pulse and that the
// previous result holds while the next operation is in progress.
module tb_approx_mult_seq;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance signals
  logic        s16, s8, s32;
  logic [15:0] a16, b16;
  logic [7:0]  a8, b8;
  logic [31:0] a32, b32;
  logic        busy16, busy8, busy32;
  logic        done16, done8, done32;
  logic [31:0] r16;
  logic [15:0] r8;
  logic [63:0] r32;
  logic        z16, z8, z32;
  logic [5:0]  st16, st8, st32;

  approx_mult_seq #(.W(16), .K(8)) u16 (
    .clk(clk), .rst(rst), .start(s16), .a_in(a16), .b_in(b16),
    .busy(busy16), .done(done16), .result(r16), .zero_out(z16), .dbg_state(st16));
  approx_mult_seq #(.W(8), .K(8)) u8 (
    .clk(clk), .rst(rst), .start(s8), .a_in(a8), .b_in(b8),
    .busy(busy8), .done(done8), .result(r8), .zero_out(z8), .dbg_state(st8));
  approx_mult_seq #(.W(32), .K(4)) u32 (
    .clk(clk), .rst(rst), .start(s32), .a_in(a32), .b_in(b32),
    .busy(busy32), .done(done32), .result(r32), .zero_out(z32), .dbg_state(st32));

  // Scoreboard counters and previous expected results per instance
  int checks = 0;
  int errors = 0;
  logic [63:0] prev_exp [3];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int w_of(input int sel);
    return (sel == 0) ? 16 : (sel == 1) ? 8 : 32;
  endfunction

  function automatic int k_of(input int sel);
    return (sel == 0) ? 8 : (sel == 1) ? 8 : 4;
  endfunction

  function automatic logic get_done(input int sel);
    return (sel == 0) ? done16 : (sel == 1) ? done8 : done32;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy16 : (sel == 1) ? busy8 : busy32;
  endfunction

  function automatic logic get_zero(input int sel);
    return (sel == 0) ? z16 : (sel == 1) ? z8 : z32;
  endfunction

  function automatic logic [63:0] get_result(input int sel);
    return (sel == 0) ? {32'd0, r16} : (sel == 1) ? {48'd0, r8} : r32;
  endfunction

  // Driver task
  task automatic set_in(input int sel, input logic st, input logic [63:0] a, input logic [63:0] b);
    case (sel)
      0: begin s16 = st; a16 = a[15:0]; b16 = b[15:0]; end
      1: begin s8  = st; a8  = a[7:0];  b8  = b[7:0];  end
      default: begin s32 = st; a32 = a[31:0]; b32 = b[31:0]; end
    endcase
  endtask

  // Reference model: normalise each operand to a set MSB, keep the top k
  // bits, multiply, scale to the 2w-bit frame, then shift down by the
  // total normalisation count.
  function automatic logic [63:0] ref_prod(input int w, input int k,
                                           input logic [63:0] a, input logic [63:0] b,
                                           output int sa, output int sb);
    logic [63:0] an, bn, ta, tb;
    an = a; bn = b; sa = 0; sb = 0;
    if (a == 0 || b == 0) return 64'd0;
    while (an < (64'd1 << (w-1))) begin an = an * 2; sa++; end
    while (bn < (64'd1 << (w-1))) begin bn = bn * 2; sb++; end
    ta = an >> (w-k);
    tb = bn >> (w-k);
    return ((ta * tb) << (2*w - 2*k)) >> (sa + sb);
  endfunction

  // One full operation, optionally with a start pulse while busy
  task automatic run_op(input int sel, input logic [63:0] a, input logic [63:0] b,
                        input bit poke, input string tag);
    int w, k, sa, sb, lat, exp_lat, busy_n;
    bit got;
    logic [63:0] exp;
    w = w_of(sel);
    k = k_of(sel);
    exp = ref_prod(w, k, a, b, sa, sb);
    exp_lat = (a == 0 || b == 0) ? 0 : 2*(sa+sb) + 4;

    @(negedge clk);
    set_in(sel, 1'b1, a, b);
    @(posedge clk);               // accepting edge 0
    @(negedge clk);
    set_in(sel, 1'b0, 64'($urandom), 64'($urandom));
    lat = 0; got = 0; busy_n = 0;
    while (!got && lat < 300) begin
      if (get_busy(sel)) busy_n++;
      if (get_done(sel)) begin
        got = 1;
      end else begin
        check({tag, "_hold"}, get_result(sel), prev_exp[sel]);
        if (poke && lat == 2) set_in(sel, 1'b1, 64'd1, 64'd1);
        else if (poke && lat == 3) set_in(sel, 1'b0, 64'd0, 64'd0);
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
    end
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy_len"}, 64'(busy_n), 64'(exp_lat + 1));
    check({tag, "_result"}, get_result(sel), exp);
    check({tag, "_zero"}, 64'(get_zero(sel)), 64'((a == 0 || b == 0) ? 1 : 0));
    if (w == k) check({tag, "_exact"}, get_result(sel), a * b);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(get_done(sel)), 64'd0);
    check({tag, "_idle_after"}, 64'(get_busy(sel)), 64'd0);
    check({tag, "_result_held"}, get_result(sel), exp);
    prev_exp[sel] = exp;
  endtask

  function automatic logic [63:0] rand_nz(input int w);
    logic [63:0] r;
    r = {32'($urandom), 32'($urandom)};
    r = r & ((64'd1 << w) - 1);
    r = r >> $urandom_range(0, w-1);
    if (r == 0) r = 64'd1;
    return r;
  endfunction

  // Directed and random sequence
  initial begin
    s16 = 0; s8 = 0; s32 = 0;
    a16 = 0; b16 = 0; a8 = 0; b8 = 0; a32 = 0; b32 = 0;
    for (int i = 0; i < 3; i++) prev_exp[i] = 64'd0;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_busy",   64'(get_busy(i)), 64'd0);
      check("reset_done",   64'(get_done(i)), 64'd0);
      check("reset_result", get_result(i), 64'd0);
      check("reset_zero",   64'(get_zero(i)), 64'd0);
    end
    check("reset_onehot", 64'($onehot(st16)), 64'd1);
    rst = 1'b1;

    run_op(0, 64'h8000, 64'h8000, 0, "w16_msb");
    run_op(0, 64'h0003, 64'h0005, 0, "w16_small");
    run_op(0, 64'h01FF, 64'h0003, 1, "w16_trunc_poke");
    run_op(0, 64'h0000, 64'h1234, 0, "w16_zero_a");
    run_op(0, 64'h0001, 64'h0001, 0, "w16_one");
    run_op(0, 64'h5678, 64'h0000, 0, "w16_zero_b");
    run_op(0, 64'hFFFF, 64'hFFFF, 0, "w16_max");

    // Reset in the middle of DENORM (entered after edge 30 for 3*5)
    @(negedge clk);
    set_in(0, 1'b1, 64'h3, 64'h5);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b0, 64'h0, 64'h0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("mid_busy_before", 64'(busy16), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_busy",   64'(busy16), 64'd0);
    check("mid_rst_done",   64'(done16), 64'd0);
    check("mid_rst_result", {32'd0, r16}, 64'd0);
    check("mid_rst_zero",   64'(z16), 64'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) prev_exp[i] = 64'd0;
    run_op(0, 64'h0003, 64'h0005, 0, "w16_after_rst");

    for (int i = 0; i < 6; i++) run_op(0, rand_nz(16), rand_nz(16), (i % 2) == 1, "w16_rand");
    run_op(1, 64'hFF, 64'hFF, 0, "w8_max");
    run_op(1, 64'h01, 64'h01, 0, "w8_min");
    for (int i = 0; i < 8; i++) run_op(1, rand_nz(8), rand_nz(8), 0, "w8_rand");
    run_op(2, 64'h1, 64'hFFFF_FFFF, 0, "w32_edge");
    for (int i = 0; i < 8; i++) run_op(2, rand_nz(32), rand_nz(32), (i % 3) == 0, "w32_rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/approx_mult_seq.md
Name: approx_mult_seq

Overview:
- Parametrised sequential approximate (leading-one truncation) unsigned multiplier: controller plus datapath in one block.
- Each operand is normalised by left-shifting until its MSB is 1, and the shift counts are accumulated. The top K bits of each operand are multiplied. The product is then denormalised by right-shifting by the total shift count.
- Successor to the fixed 8-bit-truncation multiplier controller. Adds width/truncation parameters, a start/busy/done handshake, a held result register and a zero-operand early-out (the previous generation hangs on a zero operand).

Parameters:
- W, 16, operand width in bits (W >= 2).
- K, 8, kept bits per operand after normalisation (1 <= K <= W).
- CW, $clog2(2*W), shift-counter width (derived; not to be overridden).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-low reset; sampled on the rising edge of clk.
- start  in  1  request; sampled only in IDLE.
- a_in  in  W  operand A; captured on the edge that accepts start.
- b_in  in  W  operand B; captured on the edge that accepts start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse, high only in state DONE.
- result  out  2W  approximate product; held until the next DONE entry.
- zero_out  out  1  high with result when the last operation took the zero early-out; held alongside result.

Behaviour:
- Reset (rst=0 at an edge) forces:
  - state=IDLE, busy=0, done=0, result=0, zero_out=0, counter=0.
  - This has priority over everything, including mid-operation; any partial operation is discarded.
- States: IDLE, NORM_A, NORM_B, MUL, DENORM, DONE (encoding free; one-hot preferred).
- IDLE, start=1:
  - Capture a_reg<=a_in, b_reg<=b_in, cnt<=0.
  - If a_in==0 or b_in==0: go to DONE, result<=0, zero_out<=1.
  - Otherwise go to NORM_A. start=0 stays in IDLE.
- NORM_A:
  - If a_reg[W-1]==1, go to NORM_B.
  - Else a_reg<=a_reg<<1, cnt<=cnt+1, stay.
  - Occupies sa+1 cycles, where sa = leading zeros of A.
- NORM_B: same rule on b_reg; occupies sb+1 cycles, where sb = leading zeros of B.
- MUL, one cycle:
  - sh<={a_reg[W-1:W-K]*b_reg[W-1:W-K], (2W-2K) zeros}, a 2W-bit internal shift register.
  - Go to DENORM.
- DENORM:
  - If cnt==0: result<=sh, zero_out<=0, go to DONE.
  - Else sh<=sh>>1 (zero fill), cnt<=cnt-1, stay.
  - Occupies sa+sb+1 cycles.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally. start in DONE is ignored.
- Counter range: max cnt = 2(W-1); it never wraps.
- Output stability: result/zero_out change only on entry to DONE; they are stable during the entire next operation.
- start while busy=1: ignored, no queuing. a_in/b_in are don't-care outside the accepting edge.
- Latency, counting the accepting edge as edge 0:
  - Nonzero operands: done high after edge 2(sa+sb)+4.
  - Zero operand: done high after edge 0.
- Back-to-back: start held high makes the next accept occur on the edge that leaves DONE's following IDLE cycle; minimum one IDLE cycle between operations.
- Accuracy:
  - K==W gives the exact product.
  - K<W truncates operand bits below the leading K, so the result is always <= the exact product.

Test Plan:
- W=16,K=8; A=0x8000, B=0x8000, start pulse -> done after edge 4; result=0x40000000; zero_out=0; busy high for 5 cycles.
- A=0x0003, B=0x0005 -> sa=14, sb=13; done after edge 58; result=15 (exact).
- A=0x01FF, B=0x0003 -> done after edge 46; result=0x05FA (1530, exact value 1533); result unchanged through a following operation until its DONE.
- A=0x0000, B=0x1234 -> done high after edge 0; result=0; zero_out=1; then A=0x0001, B=0x0001 -> result=1, zero_out=0.
- Reset mid-DENORM (rst=0 one edge) -> next cycle state IDLE, busy=0, done=0, result=0; a fresh start completes correctly. start pulsed while busy is ignored (single done pulse).
- Parameter sweep W=8,K=8 and W=32,K=4 with random nonzero operands -> result matches reference model (normalise, truncate to K bits, multiply, shift), and latency equals 2(sa+sb)+4.
